// File: rtl/mod_updown_counter.sv
// Parametrised up/down modulo counter: wrap or saturate at the range ends,
// synchronous clear/load with clamp, combinational terminal count, registered wrap pulse.
module mod_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             forward,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrapped
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;
    logic             r_wrapped;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_load_val;
    logic             w_wrapped_nxt;
    logic             w_at_end;

    // "End of range" depends on direction: top when counting up, zero when down.
    assign w_at_end   = forward ? (r_cnt == LAST) : (r_cnt == '0);
    assign w_load_val = (load_value > LAST) ? LAST : load_value;

    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_wrapped_nxt = 1'b0;
        if (clear) begin
            w_cnt_nxt = '0;
        end else if (load) begin
            w_cnt_nxt = w_load_val;
        end else if (enable) begin
            if (!w_at_end) begin
                w_cnt_nxt = forward ? (r_cnt + ONE) : (r_cnt - ONE);
            end else if (SATURATE == 0) begin
                w_cnt_nxt     = forward ? '0 : LAST;
                w_wrapped_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_wrapped <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_wrapped <= w_wrapped_nxt;
        end
    end

    // Terminal count is suppressed when clear/load override counting this cycle.
    assign tc      = enable & ~clear & ~load & w_at_end;
    assign out     = r_cnt;
    assign wrapped = r_wrapped;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboarded random + directed bench: wrap, saturate, full-range and an 800x525 cascade.
module tb_mod_updown_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, en, fw, clr, ld;
    logic [3:0] lv;
    logic       c_en, c_ld;
    logic [9:0] c_lo_v, c_hi_v;

    logic [3:0] w_out, s_out, f_out;
    logic       w_tc, w_wr, s_tc, s_wr, f_tc, f_wr;
    logic [9:0] lo_out, hi_out;
    logic       lo_tc, lo_wr, hi_tc, hi_wr;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .enable(en), .forward(fw), .clear(clr), .load(ld),
        .load_value(lv), .out(w_out), .tc(w_tc), .wrapped(w_wr));
    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .enable(en), .forward(fw), .clear(clr), .load(ld),
        .load_value(lv), .out(s_out), .tc(s_tc), .wrapped(s_wr));
    mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_full (
        .clk(clk), .reset(reset), .enable(en), .forward(fw), .clear(clr), .load(ld),
        .load_value(lv), .out(f_out), .tc(f_tc), .wrapped(f_wr));
    mod_updown_counter #(.WIDTH(10), .MODULUS(800), .SATURATE(0)) u_lo (
        .clk(clk), .reset(reset), .enable(c_en), .forward(1'b1), .clear(1'b0), .load(c_ld),
        .load_value(c_lo_v), .out(lo_out), .tc(lo_tc), .wrapped(lo_wr));
    mod_updown_counter #(.WIDTH(10), .MODULUS(525), .SATURATE(0)) u_hi (
        .clk(clk), .reset(reset), .enable(lo_tc), .forward(1'b1), .clear(1'b0), .load(c_ld),
        .load_value(c_hi_v), .out(hi_out), .tc(hi_tc), .wrapped(hi_wr));

    typedef struct {
        int w_out, s_out, f_out, lo_out, hi_out;
        bit w_tc, w_wr, s_tc, s_wr, f_tc, f_wr, lo_tc, lo_wr, hi_tc, hi_wr;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: plain integers per counter.
    int mw = 0, ms = 0, mf = 0, mlo = 0, mhi = 0;
    bit ww = 0, ws = 0, wf = 0, wlo = 0, whi = 0;

    function automatic bit m_tc(input int m, input bit e, input bit f, input bit c,
                                input bit l, input int cur);
        return e && !c && !l && (f ? (cur == m - 1) : (cur == 0));
    endfunction

    function automatic void m_next(input int m, input bit sat, input bit e, input bit f,
                                   input bit c, input bit l, input int lval, input int cur,
                                   output int nx, output bit wr);
        nx = cur;
        wr = 1'b0;
        if (c) nx = 0;
        else if (l) nx = (lval >= m) ? m - 1 : lval;
        else if (e) begin
            if (sat) nx = f ? ((cur + 1 > m - 1) ? m - 1 : cur + 1) : ((cur == 0) ? 0 : cur - 1);
            else begin
                nx = f ? (cur + 1) % m : (cur + m - 1) % m;
                wr = f ? (cur == m - 1) : (cur == 0);
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Called at a falling edge with inputs already applied; records what the
    // DUTs must show during this half-cycle, then advances the model across the edge.
    task automatic step();
        exp_t e;
        bit   t_lo;
        #1;
        if (!reset) begin
            mw = 0; ms = 0; mf = 0; mlo = 0; mhi = 0;
            ww = 0; ws = 0; wf = 0; wlo = 0; whi = 0;
        end
        t_lo    = m_tc(800, c_en, 1'b1, 1'b0, c_ld, mlo);
        e.w_out = mw;  e.w_tc = m_tc(10, en, fw, clr, ld, mw);  e.w_wr = ww;
        e.s_out = ms;  e.s_tc = m_tc(10, en, fw, clr, ld, ms);  e.s_wr = ws;
        e.f_out = mf;  e.f_tc = m_tc(16, en, fw, clr, ld, mf);  e.f_wr = wf;
        e.lo_out = mlo; e.lo_tc = t_lo; e.lo_wr = wlo;
        e.hi_out = mhi; e.hi_tc = m_tc(525, t_lo, 1'b1, 1'b0, c_ld, mhi); e.hi_wr = whi;
        q.push_back(e);
        if (reset) begin
            m_next(10, 1'b0, en, fw, clr, ld, int'(lv), mw, mw, ww);
            m_next(10, 1'b1, en, fw, clr, ld, int'(lv), ms, ms, ws);
            m_next(16, 1'b0, en, fw, clr, ld, int'(lv), mf, mf, wf);
            m_next(525, 1'b0, t_lo, 1'b1, 1'b0, c_ld, int'(c_hi_v), mhi, mhi, whi);
            m_next(800, 1'b0, c_en, 1'b1, 1'b0, c_ld, int'(c_lo_v), mlo, mlo, wlo);
        end
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (q.size() > 0) begin
                e = q.pop_front();
                chk("wrap.out", int'(w_out), e.w_out);   chk("wrap.tc", int'(w_tc), int'(e.w_tc));
                chk("wrap.wrapped", int'(w_wr), int'(e.w_wr));
                chk("sat.out", int'(s_out), e.s_out);    chk("sat.tc", int'(s_tc), int'(e.s_tc));
                chk("sat.wrapped", int'(s_wr), int'(e.s_wr));
                chk("full.out", int'(f_out), e.f_out);   chk("full.tc", int'(f_tc), int'(e.f_tc));
                chk("full.wrapped", int'(f_wr), int'(e.f_wr));
                chk("lo.out", int'(lo_out), e.lo_out);   chk("lo.tc", int'(lo_tc), int'(e.lo_tc));
                chk("lo.wrapped", int'(lo_wr), int'(e.lo_wr));
                chk("hi.out", int'(hi_out), e.hi_out);   chk("hi.tc", int'(hi_tc), int'(e.hi_tc));
                chk("hi.wrapped", int'(hi_wr), int'(e.hi_wr));
            end
        end
    end

    initial begin : stim
        reset = 1'b0; en = 1'b0; fw = 1'b1; clr = 1'b0; ld = 1'b0; lv = '0;
        c_en = 1'b0; c_ld = 1'b0; c_lo_v = '0; c_hi_v = '0;
        @(negedge clk);
        step(); step();
        reset = 1'b1; step();

        // Count up across the top: wrap at 9, saturate holds at 9, full range runs on.
        en = 1'b1; fw = 1'b1;
        repeat (17) step();
        fw = 1'b0; step();

        // Down through zero from a loaded 1.
        en = 1'b0; ld = 1'b1; lv = 4'd1; step();
        ld = 1'b0; en = 1'b1; fw = 1'b0;
        repeat (3) step();

        // Reset dropped between rising edges while holding at 7.
        en = 1'b0; ld = 1'b1; lv = 4'd7; step();
        ld = 1'b0; step();
        reset = 1'b0; step();
        reset = 1'b1; step(); step();

        // Priority and clamp.
        ld = 1'b1; lv = 4'd13; en = 1'b1; fw = 1'b1; step();
        ld = 1'b0; en = 1'b0; step();
        clr = 1'b1; ld = 1'b1; lv = 4'd5; en = 1'b1; step();
        clr = 1'b0; ld = 1'b0; step();
        clr = 1'b1; step();
        clr = 1'b0; en = 1'b0; step();

        // Random traffic; the cascade counts along in parallel.
        for (int i = 0; i < 2500; i++) begin
            reset = ($urandom_range(0, 599) != 0);
            en    = ($urandom_range(0, 3) != 0);
            fw    = 1'($urandom_range(0, 1));
            clr   = ($urandom_range(0, 29) == 0);
            ld    = ($urandom_range(0, 19) == 0);
            lv    = 4'($urandom_range(0, 15));
            c_en  = ($urandom_range(0, 9) != 0);
            step();
        end

        // Cascade end of frame: 524*800+795 plus five clocks returns both to 0.
        reset = 1'b1; en = 1'b0; clr = 1'b0; ld = 1'b0;
        c_en = 1'b1; c_ld = 1'b1; c_lo_v = 10'd795; c_hi_v = 10'd524; step();
        c_ld = 1'b0;
        repeat (8) step();

        @(negedge clk);
        #3;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
